// File: rtl/jt10_adpcm_rom_pkg.sv
// Shared types and default region offsets for the jt10 ADPCM ROM responder.
package jt10_adpcm_rom_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyA,
    StBusyB
  } state_e;

  typedef enum logic {
    GrantA = 1'b0,
    GrantB = 1'b1
  } grant_e;

  localparam logic [24:0] ADefaultBase = 25'h000_0000;
  localparam logic [24:0] BDefaultBase = 25'h100_0000;

endpackage

// File: rtl/jt10_adpcm_rom_if.sv
// Byte-wide shared memory port with a level request and a one-cycle acknowledge.
interface jt10_adpcm_rom_if #(
  parameter int unsigned MEM_AW = 25
);
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_data);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_data);
endinterface

// File: rtl/jt10_adpcm_rom_ch.sv
// One ADPCM port: change detection, demand generation and the held data byte.
// JT10_ADPCM_PREFETCH_EN adds a one-byte next-address buffer filled by prefetches.
module jt10_adpcm_rom_ch (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] addr,
  input  logic        roe_n,
  input  logic        start,
  input  logic        done,
  input  logic [7:0]  mem_data,
  output logic        need,
  output logic        pf_need,
  output logic [23:0] fetch_addr,
  output logic [7:0]  data
);

  logic [23:0] last_q;
  logic [23:0] pend_addr_q;
  logic        valid_q;
  logic        pend_q;
  logic [7:0]  data_q;
  logic        raw_need;

  assign raw_need = !roe_n && (!valid_q || (addr != last_q));
  assign data     = data_q;

`ifdef JT10_ADPCM_PREFETCH_EN
  logic [23:0] nxt_addr_q;
  logic [7:0]  nxt_data_q;
  logic        nxt_valid_q;
  logic        pend_pf_q;
  logic        match;
  logic        hit;

  assign match      = nxt_valid_q && (addr == nxt_addr_q);
  // A buffered hit is only taken while no fetch for this port is in flight.
  assign hit        = raw_need && match && !pend_q;
  assign need       = raw_need && !match;
  assign pf_need    = valid_q && !nxt_valid_q && !pend_q;
  assign fetch_addr = need ? addr : last_q + 24'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= '0;
      pend_addr_q <= '0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      nxt_addr_q  <= '0;
      nxt_data_q  <= '0;
      nxt_valid_q <= 1'b0;
      pend_pf_q   <= 1'b0;
    end else begin
      if (start) begin
        pend_q      <= 1'b1;
        pend_addr_q <= fetch_addr;
        pend_pf_q   <= !need;
      end
      if (done && pend_q) begin
        pend_q <= 1'b0;
        if (pend_pf_q) begin
          nxt_addr_q  <= pend_addr_q;
          nxt_data_q  <= mem_data;
          nxt_valid_q <= 1'b1;
        end else begin
          data_q  <= mem_data;
          last_q  <= pend_addr_q;
          valid_q <= 1'b1;
          // Keep the buffer only if it still follows the new address.
          if (nxt_addr_q != pend_addr_q + 24'd1) nxt_valid_q <= 1'b0;
        end
      end else if (hit) begin
        data_q      <= nxt_data_q;
        last_q      <= addr;
        valid_q     <= 1'b1;
        nxt_valid_q <= 1'b0;
      end
    end
  end
`else
  assign need       = raw_need;
  assign pf_need    = 1'b0;
  assign fetch_addr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= '0;
      pend_addr_q <= '0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      if (start) begin
        pend_q      <= 1'b1;
        pend_addr_q <= addr;
      end
      if (done && pend_q) begin
        pend_q  <= 1'b0;
        data_q  <= mem_data;
        last_q  <= pend_addr_q;
        valid_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/jt10_adpcm_rom.sv
// Serves the YM2610 ADPCM-A and ADPCM-B sample buses from one shared memory port,
// round-robin between ports. Optional prefetch via JT10_ADPCM_PREFETCH_EN.
module jt10_adpcm_rom
  import jt10_adpcm_rom_pkg::*;
#(
  parameter int unsigned       MEM_AW = 25,
  parameter logic [MEM_AW-1:0] A_BASE = MEM_AW'(ADefaultBase),
  parameter logic [MEM_AW-1:0] B_BASE = MEM_AW'(BDefaultBase)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [19:0]      adpcma_addr,
  input  logic [3:0]       adpcma_bank,
  input  logic             adpcma_roe_n,
  output logic [7:0]       adpcma_data,
  input  logic [23:0]      adpcmb_addr,
  input  logic             adpcmb_roe_n,
  output logic [7:0]       adpcmb_data,
  jt10_adpcm_rom_if.master mem
);

  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              req_q, req_d;

  logic        need_a, need_b, pf_need_a, pf_need_b;
  logic        want_a, want_b, any_need;
  logic        start_a, start_b, done_a, done_b;
  logic [23:0] fetch_a, fetch_b;

  jt10_adpcm_rom_ch u_ch_a (
    .clk        (clk),
    .rst        (rst),
    .addr       ({adpcma_bank, adpcma_addr}),
    .roe_n      (adpcma_roe_n),
    .start      (start_a),
    .done       (done_a),
    .mem_data   (mem.mem_data),
    .need       (need_a),
    .pf_need    (pf_need_a),
    .fetch_addr (fetch_a),
    .data       (adpcma_data)
  );

  jt10_adpcm_rom_ch u_ch_b (
    .clk        (clk),
    .rst        (rst),
    .addr       (adpcmb_addr),
    .roe_n      (adpcmb_roe_n),
    .start      (start_b),
    .done       (done_b),
    .mem_data   (mem.mem_data),
    .need       (need_b),
    .pf_need    (pf_need_b),
    .fetch_addr (fetch_b),
    .data       (adpcmb_data)
  );

  // Demand always outranks prefetch; within a class the port not served last wins ties.
  assign any_need = need_a | need_b;
  assign want_a   = any_need ? need_a : pf_need_a;
  assign want_b   = any_need ? need_b : pf_need_b;

  assign done_a = (state_q == StBusyA) && mem.mem_ack;
  assign done_b = (state_q == StBusyB) && mem.mem_ack;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    req_d   = req_q;
    start_a = 1'b0;
    start_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (want_a && (!want_b || (last_q == GrantB))) begin
          start_a = 1'b1;
          addr_d  = A_BASE + MEM_AW'(fetch_a);
          req_d   = 1'b1;
          state_d = StBusyA;
          last_d  = GrantA;
        end else if (want_b) begin
          start_b = 1'b1;
          addr_d  = B_BASE + MEM_AW'(fetch_b);
          req_d   = 1'b1;
          state_d = StBusyB;
          last_d  = GrantB;
        end
      end
      StBusyA, StBusyB: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= GrantB;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_req  = req_q;

endmodule

// File: tb/tb_jt10_adpcm_rom.sv
// Directed and randomized checks of jt10_adpcm_rom against a byte-per-address memory model.
module tb_jt10_adpcm_rom;

  localparam int unsigned MEM_AW = 25;
  localparam logic [24:0] A_BASE = 25'h000_0000;
  localparam logic [24:0] B_BASE = 25'h100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] a_addr = '0;
  logic [3:0]  a_bank = '0;
  logic        a_roe_n = 1'b1;
  logic [7:0]  a_data;
  logic [23:0] b_addr = '0;
  logic        b_roe_n = 1'b1;
  logic [7:0]  b_data;

  int tests = 0;
  int fails = 0;

  // Responder controls (written by the main sequence) and status (written by the responder).
  int          ack_delay = 1;
  int          force_idx = 0;
  logic [7:0]  force_val = 8'h00;
  int          inject_req = 0;
  int          inject_done = 0;
  int          acks_seen = 0;
  int          cnt = 0;

  logic [7:0] exp_a, exp_b;

  jt10_adpcm_rom_if #(.MEM_AW(MEM_AW)) mem ();

  jt10_adpcm_rom #(.MEM_AW(MEM_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .adpcma_addr  (a_addr),
    .adpcma_bank  (a_bank),
    .adpcma_roe_n (a_roe_n),
    .adpcma_data  (a_data),
    .adpcmb_addr  (b_addr),
    .adpcmb_roe_n (b_roe_n),
    .adpcmb_data  (b_data),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]} ^ 8'hA5;
  endfunction

  // Memory model: acks ack_delay cycles after the request is first seen.
  initial begin
    mem.mem_ack  = 1'b0;
    mem.mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
        cnt = 0;
      end else if (inject_req != inject_done) begin
        mem.mem_ack  = 1'b1;
        mem.mem_data = 8'hFF;
        inject_done++;
      end else if (mem.mem_req === 1'b1) begin
        if (cnt >= ack_delay) begin
          acks_seen++;
          mem.mem_data = (acks_seen == force_idx) ? force_val : mem_fn(mem.mem_addr);
          mem.mem_ack  = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 300) begin
      step(1);
      n++;
      quiet = (mem.mem_req === 1'b0) ? quiet + 1 : 0;
    end
    check("settle_quiet", 32'(quiet), 32'd3);
  endtask

  task automatic wait_req_addr(input string tag, input logic [24:0] a);
    int n = 0;
    while (!(mem.mem_req === 1'b1 && mem.mem_addr === a) && n < 100) begin
      step(1);
      n++;
    end
    check(tag, 32'(mem.mem_addr), 32'(a));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    check("rst_req", 32'(mem.mem_req), 32'd0);
    check("rst_addr", 32'(mem.mem_addr), 32'd0);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    rst = 1'b0;
    step(1);
  endtask

  // Address changes only touch roe_n when allowed, so the settled result is unambiguous.
  task automatic apply_random(input bit allow_roe);
    ack_delay = int'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) begin
      logic [23:0] na;
      na = ($urandom_range(0, 2) == 0) ? {a_bank, a_addr} + 24'd1 : 24'($urandom);
      {a_bank, a_addr} = na;
      if (allow_roe) a_roe_n = ($urandom_range(0, 4) == 0);
    end
    if ($urandom_range(0, 1) == 1) begin
      b_addr = ($urandom_range(0, 2) == 0) ? b_addr + 24'd1 : 24'($urandom);
      if (allow_roe) b_roe_n = ($urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    step(1);
    do_reset();

    // Single port A fetch with a 3-cycle ack and forced byte.
    a_bank = 4'h3;
    a_addr = 20'h00010;
    a_roe_n = 1'b0;
    ack_delay = 3;
    force_idx = acks_seen + 1;
    force_val = 8'h5A;
    step(1);
    check("t1_req", 32'(mem.mem_req), 32'd1);
    check("t1_addr", 32'(mem.mem_addr), 32'h300010);
    step(3);
    check("t1_data_early", 32'(a_data), 32'd0);
    step(1);
    check("t1_data", 32'(a_data), 32'h5A);
    settle();

    // Tie after reset: A first, B after one idle cycle.
    a_roe_n = 1'b1;
    b_roe_n = 1'b1;
    do_reset();
    ack_delay = 0;
    a_bank = 4'h0;
    a_addr = 20'h00020;
    a_roe_n = 1'b0;
    b_addr = 24'h000100;
    b_roe_n = 1'b0;
    step(1);
    check("tie1_first", 32'(mem.mem_addr), 32'h000020);
    step(1);
    check("tie1_a_data", 32'(a_data), 32'(mem_fn(25'h000020)));
    check("tie1_idle", 32'(mem.mem_req), 32'd0);
    step(1);
    check("tie1_second_req", 32'(mem.mem_req), 32'd1);
    check("tie1_second", 32'(mem.mem_addr), 32'h1000100);
    step(1);
    check("tie1_b_data", 32'(b_data), 32'(mem_fn(25'h1000100)));
    settle();

    // A alone, then a tie: B must win because A was served last.
    a_addr = 20'h00030;
    settle();
    check("a_only_data", 32'(a_data), 32'(mem_fn(25'h000030)));
    a_addr = 20'h00040;
    b_addr = 24'h000180;
    step(1);
    check("tie2_first", 32'(mem.mem_addr), 32'h1000180);
    settle();
    check("tie2_a_data", 32'(a_data), 32'(mem_fn(25'h000040)));
    check("tie2_b_data", 32'(b_data), 32'(mem_fn(25'h1000180)));

    // B address moves while its fetch is in flight.
    b_addr = 24'h000200;
    ack_delay = 3;
    step(1);
    check("busy_req_addr", 32'(mem.mem_addr), 32'h1000200);
    b_addr = 24'h000280;
    step(3);
    check("busy_ack_seen", 32'(mem.mem_ack), 32'd1);
    step(1);
    check("busy_old_byte", 32'(b_data), 32'(mem_fn(25'h1000200)));
    check("busy_idle", 32'(mem.mem_req), 32'd0);
    step(1);
    check("busy_rereq", 32'(mem.mem_req), 32'd1);
    check("busy_rereq_addr", 32'(mem.mem_addr), 32'h1000280);
    settle();
    check("busy_new_byte", 32'(b_data), 32'(mem_fn(25'h1000280)));

    // Reset while a request is outstanding, then a stray ack.
    b_addr = 24'h000300;
    ack_delay = 10;
    step(1);
    check("mid_req", 32'(mem.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem.mem_req), 32'd0);
    check("mid_rst_addr", 32'(mem.mem_addr), 32'd0);
    check("mid_rst_a", 32'(a_data), 32'd0);
    check("mid_rst_b", 32'(b_data), 32'd0);
    a_roe_n = 1'b1;
    b_roe_n = 1'b1;
    step(1);
    rst = 1'b0;
    inject_req++;
    step(2);
    check("late_ack_a", 32'(a_data), 32'd0);
    check("late_ack_b", 32'(b_data), 32'd0);
    check("late_ack_req", 32'(mem.mem_req), 32'd0);
    ack_delay = 1;

    // Output enable high: address changes must not fetch.
    a_bank = 4'h1;
    a_addr = 20'h00050;
    a_roe_n = 1'b0;
    settle();
    check("roe_fetch", 32'(a_data), 32'(mem_fn(25'h100050)));
    a_roe_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_addr = 20'($urandom);
      step(1);
      check("roe_no_req", 32'(mem.mem_req), 32'd0);
    end
    check("roe_hold", 32'(a_data), 32'(mem_fn(25'h100050)));
    exp_a = mem_fn(25'h100050);
    exp_b = 8'h00;

`ifdef JT10_ADPCM_PREFETCH_EN
    b_addr = 24'h000400;
    b_roe_n = 1'b0;
    wait_req_addr("pf_demand", 25'h1000400);
    wait_req_addr("pf_issue", 25'h1000401);
    settle();
    check("pf_first", 32'(b_data), 32'(mem_fn(25'h1000400)));
    b_addr = 24'h000401;
    step(1);
    check("pf_hit_data", 32'(b_data), 32'(mem_fn(25'h1000401)));
    check("pf_hit_no_req", 32'(mem.mem_req), 32'd0);
    settle();
    b_roe_n = 1'b1;
    exp_b = mem_fn(25'h1000401);
`endif

    // Randomized traffic; settled outputs must match the addressed bytes.
    for (int it = 0; it < 40; it++) begin
      apply_random(1'b1);
      if ($urandom_range(0, 2) == 0) begin
        step(int'($urandom_range(0, 2)));
        apply_random(1'b0);
      end
      settle();
      if (!a_roe_n) exp_a = mem_fn(A_BASE + 25'({a_bank, a_addr}));
      if (!b_roe_n) exp_b = mem_fn(B_BASE + 25'(b_addr));
      check("rand_a", 32'(a_data), 32'(exp_a));
      check("rand_b", 32'(b_data), 32'(exp_b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
